// File: rtl/pipe_trace_buffer.sv
// Retirement trace capture: records {ts, pc} of every retiring instruction
// into a DEPTH-entry buffer, with continuous, stop-when-full and trigger modes.
module pipe_trace_buffer #(
  parameter int NUM_STAGES = 5,
  parameter int PC_W       = 32,
  parameter int TS_W       = 16,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_STAGES*PC_W-1:0] stage_pc,
  input  logic [NUM_STAGES-1:0]      stage_valid,
  input  logic [1:0]                 mode,
  input  logic                       arm,
  input  logic                       stop,
  input  logic [PC_W-1:0]            trig_pc,
  input  logic                       rd_en,
  output logic [TS_W+PC_W-1:0]       rd_data,
  output logic                       rd_valid,
  output logic [AW:0]                count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       triggered,
  output logic [1:0]                 state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } st_t;

  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  st_t              st_q, st_d;
  logic [1:0]       mode_q;
  logic [PC_W-1:0]  trig_q;
  logic [TS_W-1:0]  ts;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [TS_W+PC_W-1:0] mem [DEPTH];

  logic [PC_W-1:0]  ret_pc;
  logic             retire, pop, cap;
  logic             wr_ok, ow, hit;
  logic [AW:0]      cnt_d;

  assign ret_pc = stage_pc[(NUM_STAGES-1)*PC_W +: PC_W];
  assign retire = stage_valid[NUM_STAGES-1];
  assign pop    = rd_en && (count != '0);
  assign cap    = (st_q == ARMED) || (st_q == CAPTURE);

  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);
  assign state = st_q;

  // A full buffer only overwrites in continuous mode or pre-trigger history
  always_comb begin
    wr_ok = 1'b0;
    ow    = 1'b0;
    if (retire && cap) begin
      if (pop || !full) begin
        wr_ok = 1'b1;
      end else if (mode_q == 2'd1 || st_q == ARMED) begin
        wr_ok = 1'b1;
        ow    = 1'b1;
      end
    end
    cnt_d = count;
    if (wr_ok && !pop && !ow)
      cnt_d = count + 1'b1;
    else if (!wr_ok && pop)
      cnt_d = count - 1'b1;
    hit = wr_ok && (st_q == ARMED) && (ret_pc == trig_q);
  end

  always_comb begin
    st_d = st_q;
    if (arm) begin
      case (mode)
        2'd0:    st_d = IDLE;
        2'd1:    st_d = CAPTURE;
        2'd2:    st_d = CAPTURE;
        default: st_d = ARMED;
      endcase
    end else if (stop && cap) begin
      st_d = DONE;
    end else if (hit) begin
      st_d = (cnt_d == CNT_MAX) ? DONE : CAPTURE;
    end else if (st_q == CAPTURE && mode_q != 2'd1 &&
                 wr_ok && cnt_d == CNT_MAX) begin
      st_d = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) st_q <= IDLE;
    else       st_q <= st_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= 2'd0;
      trig_q    <= '0;
      ts        <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      triggered <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (pop)
        rd_data <= mem[rd_ptr];
      if (arm) begin
        mode_q    <= mode;
        trig_q    <= trig_pc;
        ts        <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        overflow  <= 1'b0;
        triggered <= 1'b0;
      end else begin
        ts    <= ts + 1'b1;
        count <= cnt_d;
        if (wr_ok)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop || ow)
          rd_ptr <= rd_ptr + 1'b1;
        if (ow)
          overflow <= 1'b1;
        if (hit && !stop)
          triggered <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !arm && wr_ok)
      mem[wr_ptr] <= {ts, ret_pc};
  end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Randomized and directed bench for pipe_trace_buffer against a queue model.
module tb_pipe_trace_buffer;

  localparam int NS    = 5;
  localparam int PC_W  = 32;
  localparam int TS_W  = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int EW    = TS_W + PC_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [NS*PC_W-1:0] stage_pc;
  logic [NS-1:0]     stage_valid;
  logic [1:0]        mode;
  logic              arm, stop;
  logic [PC_W-1:0]   trig_pc;
  logic              rd_en;
  logic [EW-1:0]     rd_data;
  logic              rd_valid;
  logic [AW:0]       count;
  logic              empty, full, overflow, triggered;
  logic [1:0]        state;

  pipe_trace_buffer #(
    .NUM_STAGES(NS), .PC_W(PC_W), .TS_W(TS_W), .DEPTH(DEPTH), .AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .stage_pc(stage_pc),
    .stage_valid(stage_valid), .mode(mode), .arm(arm), .stop(stop),
    .trig_pc(trig_pc), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .triggered(triggered), .state(state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // model state
  logic [EW-1:0] q[$];
  int            m_state, m_mode, m_ts;
  logic [PC_W-1:0] m_trig;
  bit            m_ovf, m_trg, m_rvalid;
  logic [EW-1:0] m_rdata;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, a, s, input int md,
                            input logic [PC_W-1:0] tp, input bit ret,
                            input logic [PC_W-1:0] pc, input bit re);
    bit pop, capt, wrote;
    m_rvalid = 1'b0;
    if (r) begin
      q.delete();
      m_state = 0; m_mode = 0; m_ts = 0; m_trig = '0;
      m_ovf = 0; m_trg = 0; m_rdata = '0;
      return;
    end
    pop = re && q.size() > 0;
    if (pop) begin
      m_rdata  = q[0];
      m_rvalid = 1'b1;
    end
    if (a) begin
      q.delete();
      m_ovf = 0; m_trg = 0; m_ts = 0;
      m_mode = md; m_trig = tp;
      m_state = (md == 0) ? 0 : (md == 3) ? 1 : 2;
      return;
    end
    if (pop) void'(q.pop_front());
    capt  = (m_state == 1 || m_state == 2);
    wrote = 0;
    if (ret && capt) begin
      if (q.size() < DEPTH) begin
        q.push_back({TS_W'(m_ts), pc});
        wrote = 1;
      end else if (m_mode == 1 || m_state == 1) begin
        void'(q.pop_front());
        q.push_back({TS_W'(m_ts), pc});
        wrote = 1;
        m_ovf = 1;
      end
    end
    if (s && capt) m_state = 3;
    else if (m_state == 1 && wrote && pc == m_trig) begin
      m_trg   = 1;
      m_state = (q.size() == DEPTH) ? 3 : 2;
    end else if (m_state == 2 && m_mode != 1 && wrote && q.size() == DEPTH)
      m_state = 3;
    m_ts = (m_ts + 1) % (1 << TS_W);
  endtask

  task automatic compare();
    vectors++;
    chk("state", 64'(state), 64'(m_state));
    chk("count", 64'(count), 64'(q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("triggered", 64'(triggered), 64'(m_trg));
    chk("rd_valid", 64'(rd_valid), 64'(m_rvalid));
    if (m_rvalid) chk("rd_data", 64'(rd_data), 64'(m_rdata));
  endtask

  task automatic tick(input bit r, a, s, input int md,
                      input logic [PC_W-1:0] tp, input bit ret,
                      input logic [PC_W-1:0] pc, input bit re);
    reset = r; arm = a; stop = s; mode = 2'(md);
    trig_pc = tp; rd_en = re;
    for (int i = 0; i < NS - 1; i++)
      stage_pc[i*PC_W +: PC_W] = $urandom;
    stage_pc[(NS-1)*PC_W +: PC_W] = pc;
    stage_valid = {ret, 4'($urandom)};
    model_step(r, a, s, md, tp, ret, pc, re);
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic nop(input bit re);
    tick(0, 0, 0, 0, 0, 0, 32'h0, re);
  endtask

  task automatic retire(input logic [PC_W-1:0] pc);
    tick(0, 0, 0, 0, 0, 1, pc, 0);
  endtask

  initial begin
    reset = 1; arm = 0; stop = 0; mode = 0; trig_pc = 0; rd_en = 0;
    stage_pc = '0; stage_valid = '0;
    @(negedge clk);

    tick(1, 0, 0, 0, 0, 1, 32'h55, 1);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_rdata", 64'(rd_data), 64'd0);

    // stop-when-full
    tick(0, 1, 0, 2, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) retire(32'h100 + 4*i);
    chk("m2_state", 64'(state), 64'd3);
    chk("m2_count", 64'(count), 64'd16);
    chk("m2_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 16; i++) begin
      nop(1);
      chk("m2_pc", 64'(rd_data[PC_W-1:0]), 64'(32'h100 + 4*i));
      chk("m2_ts", 64'(rd_data[EW-1:PC_W]), 64'(i));
    end

    // continuous with ring overwrite and ts wrap
    tick(0, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) retire(32'h100 + 4*i);
    tick(0, 0, 1, 0, 0, 0, 0, 0);
    chk("m1_count", 64'(count), 64'd16);
    chk("m1_ovf", 64'(overflow), 64'd1);
    chk("m1_state", 64'(state), 64'd3);
    for (int k = 0; k < 16; k++) begin
      nop(1);
      chk("m1_pc", 64'(rd_data[PC_W-1:0]), 64'(32'h110 + 4*k));
      chk("m1_ts", 64'(rd_data[EW-1:PC_W]), 64'((k + 4) % 16));
    end

    // trigger mode
    tick(0, 1, 0, 3, 32'h120, 0, 0, 0);
    chk("m3_armed", 64'(state), 64'd1);
    for (int i = 0; i < 20; i++) begin
      retire(32'h100 + 4*i);
      if (i == 8) begin
        chk("m3_trg", 64'(triggered), 64'd1);
        chk("m3_cap", 64'(state), 64'd2);
      end
      if (i == 14) chk("m3_not_done", 64'(state), 64'd2);
      if (i == 15) chk("m3_done", 64'(state), 64'd3);
    end
    for (int i = 0; i < 16; i++) begin
      nop(1);
      chk("m3_pc", 64'(rd_data[PC_W-1:0]), 64'(32'h100 + 4*i));
    end

    // full ring with simultaneous write and pop
    tick(0, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) retire(32'h100 + 4*i);
    tick(0, 0, 0, 0, 0, 1, 32'h200, 1);
    chk("wp_count", 64'(count), 64'd16);
    chk("wp_ovf", 64'(overflow), 64'd0);
    chk("wp_rvalid", 64'(rd_valid), 64'd1);
    chk("wp_pc", 64'(rd_data[PC_W-1:0]), 64'h100);

    // reset mid-capture
    tick(0, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) retire(32'h300 + 4*i);
    chk("mid_count7", 64'(count), 64'd7);
    tick(1, 0, 0, 0, 0, 1, 32'h400, 0);
    chk("mid_count", 64'(count), 64'd0);
    chk("mid_state", 64'(state), 64'd0);
    chk("mid_empty", 64'(empty), 64'd1);
    nop(1);
    chk("mid_rvalid", 64'(rd_valid), 64'd0);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      bit r, a, s, rt, re;
      int md;
      logic [PC_W-1:0] tp, pc;
      r  = ($urandom_range(0, 299) == 0);
      a  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 59) == 0);
      rt = ($urandom_range(0, 9) < 6);
      re = ($urandom_range(0, 9) < 3);
      md = $urandom_range(0, 3);
      tp = 32'h1000 + 4*$urandom_range(0, 15);
      pc = 32'h1000 + 4*$urandom_range(0, 15);
      tick(r, a, s, md, tp, rt, pc, re);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
